// File: rtl/turn_timer_ctrl_if.sv
// Bus between the game control FSM / display logic and the turn timer
// controller. The game side drives the strobes and load value (master);
// the timer drives the countdown and status flags back (slave).
interface turn_timer_ctrl_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic             stop;
    logic             guess;
    logic [CNT_W-1:0] load_val;
    logic [1:0]       speed_sel;
    logic [CNT_W-1:0] count;
    logic             tick;
    logic             running;
    logic             expired;
    logic             timeout;

    modport master (
        output start, stop, guess, load_val, speed_sel,
        input  count, tick, running, expired, timeout
    );

    modport slave (
        input  start, stop, guess, load_val, speed_sel,
        output count, tick, running, expired, timeout
    );
endinterface

// File: rtl/turn_timer_ctrl.sv
// Hangman turn timer controller: sequences a rate divider and a one-digit
// countdown, handles start / pause-resume / guess-restart strobes and flags
// a timeout to the game FSM. All outputs are registered.
//
// Optional feature macro: TURN_TIMER_AUTO_RELOAD_EN
//   When defined, expiry reloads the countdown from load_val and keeps
//   running instead of entering DONE (a zero load_val still enters DONE).
module turn_timer_ctrl #(
    parameter int PERIOD_W    = 28,
    parameter int BASE_PERIOD = 50000000,
    parameter int CNT_W       = 4
) (
    input  logic              clock,
    input  logic              reset,
    turn_timer_ctrl_if.slave  tt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [PERIOD_W-1:0] BASE_P = PERIOD_W'(BASE_PERIOD);
    localparam logic [PERIOD_W-1:0] P_ZERO = {PERIOD_W{1'b0}};
    localparam logic [PERIOD_W-1:0] P_ONE  = {{(PERIOD_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]    C_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]    C_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              state_r;
    state_t              state_next_s;
    logic [CNT_W-1:0]    count_r;
    logic [CNT_W-1:0]    count_next_s;
    logic [PERIOD_W-1:0] div_r;
    logic [PERIOD_W-1:0] div_next_s;
    logic [PERIOD_W-1:0] period_r;
    logic [PERIOD_W-1:0] period_next_s;
    logic                wrap_evt_s;
    logic                expire_evt_s;

    // Shared reload decision used by start and guess.
    state_t              load_state_s;
    logic [CNT_W-1:0]    load_count_s;
    logic                load_expire_s;

    logic                tick_s;
    logic                expired_s;
    logic                running_s;
    logic                timeout_s;
    logic                tick_r;
    logic                expired_r;
    logic                running_r;
    logic                timeout_r;

    // Reload outcome: a zero load value expires immediately into DONE.
    always_comb begin
        if (tt.load_val == C_ZERO) begin
            load_state_s  = ST_DONE;
            load_count_s  = C_ZERO;
            load_expire_s = 1'b1;
        end else begin
            load_state_s  = ST_RUN;
            load_count_s  = tt.load_val;
            load_expire_s = 1'b0;
        end
    end

    // Next-state and datapath: priority start > stop > guess > divider wrap.
    always_comb begin
        state_next_s  = state_r;
        count_next_s  = count_r;
        div_next_s    = div_r;
        period_next_s = period_r;
        wrap_evt_s    = 1'b0;
        expire_evt_s  = 1'b0;
        if (tt.start) begin
            // Start is honoured in every state and re-latches the speed.
            state_next_s  = load_state_s;
            count_next_s  = load_count_s;
            div_next_s    = P_ZERO;
            period_next_s = BASE_P >> tt.speed_sel;
            expire_evt_s  = load_expire_s;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_next_s = ST_IDLE;
                end
                ST_RUN: begin
                    if (tt.stop) begin
                        // Freeze divider and count where they are.
                        state_next_s = ST_PAUSE;
                    end else if (tt.guess) begin
                        state_next_s = load_state_s;
                        count_next_s = load_count_s;
                        div_next_s   = P_ZERO;
                        expire_evt_s = load_expire_s;
                    end else if (div_r == (period_r - P_ONE)) begin
                        wrap_evt_s = 1'b1;
                        div_next_s = P_ZERO;
                        if (count_r <= C_ONE) begin
                            expire_evt_s = 1'b1;
`ifdef TURN_TIMER_AUTO_RELOAD_EN
                            state_next_s = load_state_s;
                            count_next_s = load_count_s;
`else
                            state_next_s = ST_DONE;
                            count_next_s = C_ZERO;
`endif
                        end else begin
                            count_next_s = count_r - C_ONE;
                        end
                    end else begin
                        div_next_s = div_r + P_ONE;
                    end
                end
                ST_PAUSE: begin
                    // Resume continues from the frozen divider value.
                    if (tt.stop) begin
                        state_next_s = ST_RUN;
                    end else begin
                        state_next_s = ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    count_next_s = C_ZERO;
                end
                default: begin
                    state_next_s = ST_IDLE;
                    count_next_s = C_ZERO;
                    div_next_s   = P_ZERO;
                end
            endcase
        end
    end

    // Output decode from the upcoming state so flags line up with the state.
    always_comb begin
        tick_s    = wrap_evt_s;
        expired_s = expire_evt_s;
        running_s = (state_next_s == ST_RUN);
        timeout_s = (state_next_s == ST_DONE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            count_r   <= C_ZERO;
            div_r     <= P_ZERO;
            period_r  <= BASE_P;
            tick_r    <= 1'b0;
            expired_r <= 1'b0;
            running_r <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            count_r   <= count_next_s;
            div_r     <= div_next_s;
            period_r  <= period_next_s;
            tick_r    <= tick_s;
            expired_r <= expired_s;
            running_r <= running_s;
            timeout_r <= timeout_s;
        end
    end

    assign tt.count   = count_r;
    assign tt.tick    = tick_r;
    assign tt.expired = expired_r;
    assign tt.running = running_r;
    assign tt.timeout = timeout_r;

endmodule
